// File: rtl/systolic_pe_dbuf.sv
// systolic_pe_dbuf: signed MAC PE with double-buffered weights and runtime WS/OS dataflow modes.
// Define PE_SAT_EN for saturating additions and the sticky sat_flag output.
module systolic_pe_dbuf #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    output logic              w_pending,
    input  logic              os_mode_req,
    output logic              os_mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    input  logic              drain,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid
`ifdef PE_SAT_EN
    ,
    output logic              sat_flag
`endif
);
    typedef enum logic {WS = 1'b0, OS = 1'b1} mode_t;
    mode_t state, state_next;

    logic signed [DATA_W-1:0]   shadow, w_act;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, ws_raw, os_raw, ws_sum, os_sum;
    logic                       mode_change;

    assign prod     = w_act * $signed(data_in);
    assign prod_ext = ACC_W'(prod);
    assign ws_raw   = $signed(psum_in) + prod_ext;
    assign os_raw   = acc + prod_ext;

`ifdef PE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic ws_ovf, os_ovf;

    // Overflow only when both operands share a sign and the result's sign differs.
    assign ws_ovf = (psum_in[ACC_W-1] == prod_ext[ACC_W-1]) && (ws_raw[ACC_W-1] != psum_in[ACC_W-1]);
    assign os_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (os_raw[ACC_W-1] != acc[ACC_W-1]);
    assign ws_sum = ws_ovf ? (psum_in[ACC_W-1] ? SAT_MIN : SAT_MAX) : ws_raw;
    assign os_sum = os_ovf ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : os_raw;

    always_ff @(posedge clk) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (valid_in && ((state == WS && ws_ovf) || (state == OS && !drain && os_ovf)))
            sat_flag <= 1'b1;
    end
`else
    assign ws_sum = ws_raw;
    assign os_sum = os_raw;
`endif

    // Mode may only change on an idle cycle so no accumulation straddles the switch.
    always_comb begin
        state_next = state;
        if (!valid_in && !drain)
            state_next = os_mode_req ? OS : WS;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= WS;
        else
            state <= state_next;
    end

    assign mode_change = (state_next != state);
    assign os_mode     = (state == OS);

    // A load coinciding with a swap bypasses the shadow so the new weight lands in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            w_act     <= '0;
            w_pending <= 1'b0;
        end else begin
            if (w_load)
                shadow <= w_in;
            if (w_swap)
                w_act <= w_load ? w_in : shadow;
            if (w_swap)
                w_pending <= 1'b0;
            else if (w_load)
                w_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            psum_out   <= '0;
            psum_valid <= 1'b0;
            acc        <= '0;
        end else begin
            data_out  <= data_in;
            valid_out <= valid_in;
            if (state == WS) begin
                psum_valid <= psum_valid_in | valid_in;
                psum_out   <= valid_in ? ws_sum : psum_in;
            end else if (drain) begin
                psum_out   <= acc;
                psum_valid <= 1'b1;
                acc        <= valid_in ? prod_ext : '0;
            end else begin
                psum_out   <= psum_in;
                psum_valid <= psum_valid_in;
                if (valid_in)
                    acc <= os_sum;
            end
            if (mode_change)
                acc <= '0;
        end
    end

`ifdef DEBUG
    always_ff @(posedge clk) begin
        if (!rst && state == OS && drain && psum_valid_in)
            $display("systolic_pe_dbuf: drain collided with psum_valid_in, psum_in dropped");
    end
`endif

endmodule

// File: tb/tb_systolic_pe_dbuf.sv
// Directed bench for systolic_pe_dbuf (DATA_W=8, ACC_W=16); expected outputs queued per driven cycle.
module tb_systolic_pe_dbuf;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
`ifdef PE_SAT_EN
    localparam int E_POS = 32767;
    localparam int E_NEG = -32768;
`else
    localparam int E_POS = -16707;
    localparam int E_NEG = 17280;
`endif

    logic clk = 1'b0;
    logic rst;
    logic signed [DATA_W-1:0] w_in, data_in, data_out;
    logic w_load, w_swap, w_pending, os_mode_req, os_mode;
    logic valid_in, valid_out, psum_valid_in, drain, psum_valid;
    logic signed [ACC_W-1:0] psum_in, psum_out;
`ifdef PE_SAT_EN
    logic sat_flag;
`endif

    typedef struct {
        int psum;
        int pv;
        int dout;
        int vout;
        int wp;
        int om;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    systolic_pe_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .w_pending(w_pending),
        .os_mode_req(os_mode_req), .os_mode(os_mode),
        .data_in(data_in), .valid_in(valid_in), .data_out(data_out), .valid_out(valid_out),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in), .drain(drain),
        .psum_out(psum_out), .psum_valid(psum_valid)
`ifdef PE_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int wi, input int ld, input int sw, input int req,
                        input int d, input int v, input int p, input int pv, input int dr,
                        input int e_psum, input int e_pv, input int e_wp, input int e_om,
                        input string tag);
        exp_t e;
        w_in = DATA_W'(wi); w_load = ld[0]; w_swap = sw[0]; os_mode_req = req[0];
        data_in = DATA_W'(d); valid_in = v[0]; psum_in = ACC_W'(p); psum_valid_in = pv[0];
        drain = dr[0];
        e.psum = e_psum; e.pv = e_pv; e.dout = d; e.vout = v; e.wp = e_wp; e.om = e_om;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".psum_out"}, 32'(psum_out), e.psum);
        chk({tag, ".psum_valid"}, 32'(psum_valid), e.pv);
        chk({tag, ".data_out"}, 32'(data_out), e.dout);
        chk({tag, ".valid_out"}, 32'(valid_out), e.vout);
        chk({tag, ".w_pending"}, 32'(w_pending), e.wp);
        chk({tag, ".os_mode"}, 32'(os_mode), e.om);
    endtask

    task automatic reset_check(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".psum_out"}, 32'(psum_out), 0);
        chk({tag, ".psum_valid"}, 32'(psum_valid), 0);
        chk({tag, ".data_out"}, 32'(data_out), 0);
        chk({tag, ".valid_out"}, 32'(valid_out), 0);
        chk({tag, ".w_pending"}, 32'(w_pending), 0);
        chk({tag, ".os_mode"}, 32'(os_mode), 0);
`ifdef PE_SAT_EN
        chk({tag, ".sat_flag"}, 32'(sat_flag), 0);
`endif
    endtask

    initial begin
        // reset with every input active
        rst = 1'b1;
        w_in = 8'sd5; w_load = 1'b1; w_swap = 1'b1; os_mode_req = 1'b1;
        data_in = 8'sd3; valid_in = 1'b1; psum_in = 16'sd9; psum_valid_in = 1'b1; drain = 1'b1;
        @(posedge clk);
        reset_check("rst");
        rst = 1'b0;

        // WS basics
        step(3, 1, 1, 0,  0, 0,   0, 0, 0,   0, 0, 0, 0, "ws_load");
        step(0, 0, 0, 0, -4, 1, 100, 0, 0,  88, 1, 0, 0, "ws_mac");
        step(0, 0, 0, 0,  0, 0,  55, 1, 0,  55, 1, 0, 0, "ws_pass_v");
        step(0, 0, 0, 0,  0, 0,  77, 0, 0,  77, 0, 0, 0, "ws_pass_nv");

        // double buffer
        step(2, 1, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, "db_w2");
        step(5, 1, 0, 0, 1, 1, 10, 0, 0, 12, 1, 1, 0, "db_load5");
        step(0, 0, 0, 0, 1, 1, 10, 0, 0, 12, 1, 1, 0, "db_hold");
        step(0, 0, 1, 0, 1, 1, 10, 0, 0, 12, 1, 0, 0, "db_swap");
        step(0, 0, 0, 0, 1, 1, 10, 0, 0, 15, 1, 0, 0, "db_new5");
        step(7, 1, 1, 0, 1, 1, 10, 0, 0, 15, 1, 0, 0, "db_bypass");
        step(0, 0, 0, 0, 1, 1, 10, 0, 0, 17, 1, 0, 0, "db_new7");
        step(0, 0, 0, 1, 0, 0,  5, 0, 1,  5, 0, 0, 0, "ws_drain_ign");

        // OS accumulate and drain
        step(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "os_enter");
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "os_acc1");
        step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, "os_acc2");
        step(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, "os_acc3");
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 12, 1, 0, 1, "os_drain12");
        step(0, 0, 0, 1, 4, 1, 0, 0, 1, 0, 1, 0, 1, "os_drain_d4");
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 8, 1, 0, 1, "os_drain8");
        step(0, 0, 0, 1, 0, 0, 33, 1, 0, 33, 1, 0, 1, "os_shift");
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "os_acc_b");
        step(0, 0, 0, 1, 0, 0, 999, 1, 1, 2, 1, 0, 1, "os_collide");

        // mode request gating
        step(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, "req_blocked");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "req_to_ws");
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 1, 0, 0, "req_blocked_ws");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "req_to_os");
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, "os_drain0");

        // saturation / wrap boundary
        step(127, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_setup");
`ifdef PE_SAT_EN
        chk("sat_flag_clear", 32'(sat_flag), 0);
`endif
        step(0, 0, 0, 0, 127, 1, 32700, 0, 0, E_POS, 1, 0, 0, "sat_pos");
`ifdef PE_SAT_EN
        chk("sat_flag_set", 32'(sat_flag), 1);
`endif
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 127, 1, 0, 0, "sat_after");
`ifdef PE_SAT_EN
        chk("sat_flag_sticky", 32'(sat_flag), 1);
`endif
        step(0, 0, 0, 0, -128, 1, -32000, 0, 0, E_NEG, 1, 0, 0, "sat_neg");

        // reset mid-operation clears shadow and in-flight psum
        step(9, 1, 0, 0, 5, 1, 40, 1, 0, 675, 1, 1, 0, "pre_rst");
        rst = 1'b1;
        w_load = 1'b0; valid_in = 1'b1; data_in = 8'sd5; psum_in = 16'sd40; psum_valid_in = 1'b1;
        reset_check("mid_rst");
        rst = 1'b0;
        step(0, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, "post_rst_swap");
        step(0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, "post_rst_w0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
